pll_lock_monitor: RTL and testbench
===================================

// Module: pll_lock_monitor
// PURPOSE
//  Watches the iCE40 PLL LOCK output and generates a clean, debounced reset for the
//  VGA timing/pixel logic. Runs on the 12 MHz board clock, so it keeps working while
//  the PLL output is stopped or unstable. Also tracks lock-loss events for debug LEDs.
//  Sits between the PLL wrapper and the VGA core; consumers resynchronise pll_reset.
// PARAMETERS
//  STABLE_CYCLES    16  consecutive synced-lock cycles required before release (>=1)
//  MIN_HOLD_CYCLES  8   minimum cycles spent in LOST after a loss, lock ignored (>=1)
//  COUNT_WIDTH      8   width of the saturating loss counter
// PORTS
//  clock       in   1            12 MHz board clock
//  reset       in   1            synchronous, active-high
//  locked      in   1            PLL LOCK, asynchronous to clock
//  clear_flag  in   1            one-cycle pulse, clears lock_lost
//  pll_reset   out  1            reset for downstream logic, active-high
//  ready       out  1            registered, always ~pll_reset
//  lock_lost   out  1            sticky: at least one loss since last clear
//  loss_count  out  COUNT_WIDTH  number of RUNNING->LOST transitions, saturating
//  state       out  2            FSM state code, for debug
// BEHAVIOUR
//  Reset (any edge where reset=1, including mid-operation): state=WAIT_STABLE,
//   pll_reset=1, ready=0, lock_lost=0, loss_count=0, both counters=0, sync flops=0.
//  locked passes through a 2-flop synchroniser -> lock_sync. It lags locked by 2 edges.
//  States are WAIT_STABLE=2'd0, RUNNING=2'd1, LOST=2'd2. Code 2'd3 is illegal and
//   goes to WAIT_STABLE on the next edge with pll_reset=1.
//  WAIT_STABLE: pll_reset=1.
//   - lock_sync=0: stable_cnt<=0.
//   - lock_sync=1 and stable_cnt<STABLE_CYCLES-1: stable_cnt++.
//   - lock_sync=1 and stable_cnt==STABLE_CYCLES-1: go to RUNNING, with pll_reset<=0
//     and ready<=1 on the same edge.
//   - Latency: if N is the first edge sampling locked=1, pll_reset is low after edge
//     N+STABLE_CYCLES+1. Any 0 on lock_sync restarts the full count.
//  RUNNING: pll_reset=0.
//   - lock_sync=0: go to LOST. On that edge pll_reset<=1, ready<=0, lock_lost<=1,
//     loss_count<=loss_count+1 (held at 2^COUNT_WIDTH-1), hold_cnt<=0.
//   - Loss latency: if N is the first edge sampling locked=0, pll_reset is high after
//     edge N+2.
//  LOST: pll_reset=1. hold_cnt++ each edge regardless of lock_sync.
//   - At hold_cnt==MIN_HOLD_CYCLES-1: go to WAIT_STABLE with stable_cnt<=0.
//   - Lock cycles seen during LOST never count toward stability.
//  clear_flag: lock_lost<=0 on the next edge. If a loss happens on the same edge, the
//   set wins and lock_lost stays 1. clear_flag does not affect loss_count.
//  No combinational path from any input to any output; every output is registered.
//  Counter widths are $clog2 of the respective parameter, minimum 1 bit.
// STRUCTURE
//  pll_defs.vh (shared include): state code localparams ST_WAIT_STABLE, ST_RUNNING,
//   ST_LOST, plus default STABLE_CYCLES/MIN_HOLD_CYCLES for the 12 MHz board.
//  Sub-module sync_2ff (1-bit, reset to 0): reused later for other async inputs.
//  Top level holds the FSM, stable_cnt, hold_cnt, loss counter and sticky flag.
// TESTING (STABLE_CYCLES=16, MIN_HOLD_CYCLES=8, COUNT_WIDTH=2 unless noted)
//  1. Release out of reset: reset for 3 edges, then locked=1 first sampled at edge 10
//     -> pll_reset=1 through edge 26, 0 after edge 27; ready mirrors it; state=1.
//  2. Glitch while waiting: locked drops for 1 cycle after 10 good synced cycles
//     -> no release; release occurs 16 synced-high cycles after lock_sync returns to 1.
//  3. Loss while running: locked=0 first sampled at edge N
//     -> pll_reset=1 after edge N+2, loss_count 0->1, lock_lost=1.
//     With locked back high at N+3: LOST for 8 edges, then 16 more before release.
//  4. Saturation: 5 full loss/relock cycles -> loss_count reads 1,2,3,3,3.
//  5. Flag priority: clear_flag pulsed on the same edge as a loss -> lock_lost stays 1.
//     clear_flag alone a later cycle -> lock_lost=0 next edge, loss_count unchanged.
//  6. Reset mid-operation: reset=1 for one edge in RUNNING with loss_count=2
//     -> next edge pll_reset=1, ready=0, lock_lost=0, loss_count=0, state=0.
//     Release then takes the full 16+2 cycles with locked held high.

Source files
------------

// File: rtl/pll_lock_monitor_pkg.sv
// Shared definitions for the PLL lock monitor: FSM state codes and 12 MHz board defaults.
package pll_lock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_STABLE = 2'd0,
        ST_RUNNING     = 2'd1,
        ST_LOST        = 2'd2
    } pll_state_e;

    localparam int unsigned DEF_STABLE_CYCLES   = 16;
    localparam int unsigned DEF_MIN_HOLD_CYCLES = 8;
    localparam int unsigned DEF_COUNT_WIDTH     = 8;

    // Bits needed for a counter that runs 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_monitor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both stages clear to 0 on reset.
module pll_lock_monitor_sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Debounces PLL LOCK into a clean reset for the VGA domain and keeps lock-loss debug state.
module pll_lock_monitor
    import pll_lock_monitor_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int unsigned MIN_HOLD_CYCLES = DEF_MIN_HOLD_CYCLES,
    parameter int unsigned COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   locked,
    input  logic                   clear_flag,
    output logic                   pll_reset,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [COUNT_WIDTH-1:0] loss_count,
    output logic [1:0]             state
);

    localparam int unsigned SW = cnt_width(STABLE_CYCLES);
    localparam int unsigned HW = cnt_width(MIN_HOLD_CYCLES);
    localparam logic [SW-1:0]          STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0]          HOLD_LAST   = HW'(MIN_HOLD_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] LOSS_MAX    = '1;

    logic lock_sync;

    pll_lock_monitor_sync_2ff u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (locked),
        .q_o   (lock_sync)
    );

    pll_state_e             state_q, state_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [COUNT_WIDTH-1:0] loss_q, loss_d;
    logic                   lost_q, lost_d;
    logic                   pll_reset_q, pll_reset_d;
    logic                   ready_q, ready_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_WAIT_STABLE;
            stable_q    <= '0;
            hold_q      <= '0;
            loss_q      <= '0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stable_q    <= stable_d;
            hold_q      <= hold_d;
            loss_q      <= loss_d;
            lost_q      <= lost_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        hold_d   = hold_q;
        loss_d   = loss_q;
        lost_d   = lost_q;

        // A loss below overrides this, so a coincident set beats the clear.
        if (clear_flag) begin
            lost_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_STABLE: begin
                if (!lock_sync) begin
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d = ST_RUNNING;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            ST_RUNNING: begin
                if (!lock_sync) begin
                    state_d = ST_LOST;
                    hold_d  = '0;
                    lost_d  = 1'b1;
                    if (loss_q != LOSS_MAX) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            ST_LOST: begin
                // Lock is ignored here; stability counting restarts from zero on exit.
                if (hold_q == HOLD_LAST) begin
                    state_d  = ST_WAIT_STABLE;
                    stable_d = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_WAIT_STABLE;
                stable_d = '0;
            end
        endcase

        pll_reset_d = (state_d != ST_RUNNING);
        ready_d     = (state_d == ST_RUNNING);
    end

    assign pll_reset  = pll_reset_q;
    assign ready      = ready_q;
    assign lock_lost  = lost_q;
    assign loss_count = loss_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: segment table, corner-case sequences and random traffic vs a model.
module tb_pll_lock_monitor;

    localparam int STABLE = 16;
    localparam int HOLD   = 8;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          locked;
    logic          clear_flag;
    logic          pll_reset;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] loss_count;
    logic [1:0]    state;

    pll_lock_monitor #(
        .STABLE_CYCLES   (STABLE),
        .MIN_HOLD_CYCLES (HOLD),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .locked     (locked),
        .clear_flag (clear_flag),
        .pll_reset  (pll_reset),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count),
        .state      (state)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 waiting, 1 running, 2 lost; run = consecutive synced-high
    // samples while waiting, left = edges still to spend in lost.
    int m_mode = 0;
    int m_run  = 0;
    int m_left = 0;
    int m_cnt  = 0;
    bit m_flag = 1'b0;
    bit m_d1   = 1'b0;
    bit m_d2   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ls;
        bit set_now;
        ls      = m_d2;
        set_now = 1'b0;
        if (reset) begin
            m_mode = 0; m_run = 0; m_left = 0; m_cnt = 0;
            m_flag = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
        end else begin
            m_d2 = m_d1;
            m_d1 = locked;
            if (m_mode == 0) begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == STABLE) begin
                    m_mode = 1;
                    m_run  = 0;
                end
            end else if (m_mode == 1) begin
                if (!ls) begin
                    m_mode  = 2;
                    m_left  = HOLD;
                    set_now = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0;
                    m_run  = 0;
                end
            end
            if (set_now) m_flag = 1'b1;
            else if (clear_flag) m_flag = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("model_pll_reset",  pll_reset,  (m_mode != 1));
        check("model_ready",      ready,      (m_mode == 1));
        check("model_lock_lost",  lock_lost,  m_flag);
        check("model_loss_count", loss_count, m_cnt);
        check("model_state",      state,      m_mode);
    endtask

    typedef struct {
        logic rst;
        logic lck;
        logic clr;
        int   n;
        logic e_prst;
        logic e_rdy;
        logic e_ll;
        int   e_cnt;
        int   e_st;
    } seg_t;

    seg_t tbl[16];
    int   sat_exp[5];

    initial begin
        reset      = 1'b1;
        locked     = 1'b0;
        clear_flag = 1'b0;

        //          rst   lck   clr    n   prst  rdy   ll  cnt st
        tbl[0]  = '{1'b1, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 17, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1, 1, 2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0,  7, 1'b1, 1'b0, 1'b1, 1, 2};
        tbl[6]  = '{1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1, 1, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 15, 1'b1, 1'b0, 1'b1, 1, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b1, 1, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b0, 1, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b1, 2, 2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 24, 1'b0, 1'b1, 1'b1, 2, 1};
        tbl[13] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 17, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[15] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 1};

        sat_exp = '{1, 2, 3, 3, 3};

        // Segment table: hold inputs for n edges, then compare against fixed values.
        for (int i = 0; i < 16; i++) begin
            reset      = tbl[i].rst;
            locked     = tbl[i].lck;
            clear_flag = tbl[i].clr;
            for (int k = 0; k < tbl[i].n; k++) step();
            check($sformatf("seg%0d_pll_reset", i),  pll_reset,  tbl[i].e_prst);
            check($sformatf("seg%0d_ready", i),      ready,      tbl[i].e_rdy);
            check($sformatf("seg%0d_lock_lost", i),  lock_lost,  tbl[i].e_ll);
            check($sformatf("seg%0d_loss_count", i), loss_count, tbl[i].e_cnt);
            check($sformatf("seg%0d_state", i),      state,      tbl[i].e_st);
        end
        clear_flag = 1'b0;

        // One-cycle glitch while waiting: release only 16 synced-high cycles after recovery.
        reset  = 1'b1;
        locked = 1'b0;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            locked = (e != 12);
            step();
            check($sformatf("glitch_e%0d_pll_reset", e), pll_reset, (e < 30));
        end

        // Repeated loss/relock: counter saturates at its maximum.
        reset  = 1'b1;
        locked = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 18; k++) step();
        check("sat_start_ready", ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            locked = 1'b0;
            for (int k = 0; k < 3; k++) step();
            check($sformatf("sat%0d_loss_count", i), loss_count, sat_exp[i]);
            check($sformatf("sat%0d_pll_reset", i), pll_reset, 1'b1);
            locked = 1'b1;
            for (int k = 0; k < 24; k++) step();
            check($sformatf("sat%0d_relock_ready", i), ready, 1'b1);
        end

        // Random traffic with long lock runs, occasional clears and rare resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) locked = ~locked;
            clear_flag = ($urandom_range(0, 15) == 0);
            reset      = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
